// File: rtl/switch_press_counter_if.sv
// Switch/clear inputs and BCD/segment outputs of the press counter.
interface switch_press_counter_if;
   logic       i_sw;
   logic       i_clr;
   logic [3:0] o_ones;
   logic [3:0] o_tens;
   logic [6:0] o_seg1_n;
   logic [6:0] o_seg2_n;
   logic       o_wrap;

   modport master (
      output i_sw,
      output i_clr,
      input  o_ones,
      input  o_tens,
      input  o_seg1_n,
      input  o_seg2_n,
      input  o_wrap
   );

   modport slave (
      input  i_sw,
      input  i_clr,
      output o_ones,
      output o_tens,
      output o_seg1_n,
      output o_seg2_n,
      output o_wrap
   );
endinterface

// File: rtl/switch_press_counter.sv
// Two-digit BCD press counter with hold-to-auto-repeat and 7-segment outputs.
module switch_press_counter #(
   parameter int c_holdCount   = 12500000,
   parameter int c_repeatCount = 2500000
) (
   input logic                   i_clk,
   input logic                   i_rst,
   switch_press_counter_if.slave bus
);

   localparam int max_count = (c_holdCount > c_repeatCount) ?
                              c_holdCount : c_repeatCount;
   localparam int need_w    = $clog2(max_count + 1);
   localparam int cnt_w     = (need_w > 24) ? need_w : 24;

   localparam logic [cnt_w-1:0] hold_last   = cnt_w'(c_holdCount - 1);
   localparam logic [cnt_w-1:0] repeat_last = cnt_w'(c_repeatCount - 1);

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      REPEAT
   } state_t;

   state_t           r_state;
   logic [cnt_w-1:0] r_cnt;
   logic             r_prev;
   logic             r_inc;
   logic [3:0]       r_ones;
   logic [3:0]       r_tens;
   logic             r_wrap;
   logic [6:0]       r_seg1_n;
   logic [6:0]       r_seg2_n;
   logic             w_rise;

   assign w_rise = bus.i_sw & ~r_prev;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h01;
         4'd1:    s = 7'h4F;
         4'd2:    s = 7'h12;
         4'd3:    s = 7'h06;
         4'd4:    s = 7'h4C;
         4'd5:    s = 7'h24;
         4'd6:    s = 7'h20;
         4'd7:    s = 7'h0F;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h04;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   // r_prev tracks the switch even in reset so a held switch is not a new press.
   always_ff @(posedge i_clk) begin
      r_prev <= bus.i_sw;
   end

   // Increment requests are registered; a clear in the issuing cycle drops them.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_inc   <= 1'b0;
      end else begin
         r_inc <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_rise) begin
                  r_inc   <= ~bus.i_clr;
                  r_cnt   <= '0;
                  r_state <= HOLD;
               end
            end
            HOLD: begin
               if (!bus.i_sw) begin
                  r_cnt   <= '0;
                  r_state <= IDLE;
               end else if (r_cnt == hold_last) begin
                  r_inc   <= ~bus.i_clr;
                  r_cnt   <= '0;
                  r_state <= REPEAT;
               end else begin
                  r_cnt <= r_cnt + cnt_w'(1);
               end
            end
            REPEAT: begin
               if (!bus.i_sw) begin
                  r_cnt   <= '0;
                  r_state <= IDLE;
               end else if (r_cnt == repeat_last) begin
                  r_inc <= ~bus.i_clr;
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + cnt_w'(1);
               end
            end
            default: begin
               r_cnt   <= '0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ones   <= 4'd0;
         r_tens   <= 4'd0;
         r_wrap   <= 1'b0;
         r_seg1_n <= 7'h01;
         r_seg2_n <= 7'h01;
      end else begin
         r_wrap <= 1'b0;
         if (bus.i_clr) begin
            r_ones <= 4'd0;
            r_tens <= 4'd0;
         end else if (r_inc) begin
            if (r_ones == 4'd9) begin
               r_ones <= 4'd0;
               if (r_tens == 4'd9) begin
                  r_tens <= 4'd0;
                  r_wrap <= 1'b1;
               end else begin
                  r_tens <= r_tens + 4'd1;
               end
            end else begin
               r_ones <= r_ones + 4'd1;
            end
         end
         r_seg1_n <= seg_decode(r_tens);
         r_seg2_n <= seg_decode(r_ones);
      end
   end

   assign bus.o_ones   = r_ones;
   assign bus.o_tens   = r_tens;
   assign bus.o_wrap   = r_wrap;
   assign bus.o_seg1_n = r_seg1_n;
   assign bus.o_seg2_n = r_seg2_n;

endmodule

// File: tb/tb_switch_press_counter.sv
// Scoreboard bench for switch_press_counter with short hold/repeat times.
module tb_switch_press_counter;

   logic i_clk;
   logic i_rst;
   int   cyc;
   int   n_cmp;
   int   n_bad;

   switch_press_counter_if bus ();

   switch_press_counter #(
      .c_holdCount  (8),
      .c_repeatCount(4)
   ) dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .bus  (bus)
   );

   typedef struct {
      int          at;
      string       tag;
      logic [22:0] val;
   } exp_t;

   exp_t sb[$];

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc = cyc + 1;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h01;
         4'd1:    s = 7'h4F;
         4'd2:    s = 7'h12;
         4'd3:    s = 7'h06;
         4'd4:    s = 7'h4C;
         4'd5:    s = 7'h24;
         4'd6:    s = 7'h20;
         4'd7:    s = 7'h0F;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h04;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   task automatic check(input string tag, input logic [22:0] got,
                        input logic [22:0] want);
      n_cmp = n_cmp + 1;
      if (got !== want) begin
         n_bad = n_bad + 1;
         $display("FAIL %s @cyc %0d: got %h want %h", tag, cyc, got, want);
      end
   endtask

   // Expected {wrap, tens, ones, seg1, seg2}; segments given as the digits they show.
   task automatic expect_at(input int at, input string tag,
                            input logic [3:0] t, input logic [3:0] o,
                            input logic w,
                            input logic [3:0] st, input logic [3:0] so);
      exp_t e;
      e.at  = at;
      e.tag = tag;
      e.val = {w, t, o, seg_of(st), seg_of(so)};
      sb.push_back(e);
   endtask

   always @(negedge i_clk) begin
      while (sb.size() != 0 && sb[0].at <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         check(e.tag, {bus.o_wrap, bus.o_tens, bus.o_ones,
                       bus.o_seg1_n, bus.o_seg2_n}, e.val);
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge i_clk);
         #2;
      end
   endtask

   task automatic press1();
      bus.i_sw = 1'b1;
      step(1);
      bus.i_sw = 1'b0;
      step(1);
   endtask

   task automatic preload(input int n);
      bus.i_clr = 1'b1;
      step(1);
      bus.i_clr = 1'b0;
      for (int i = 0; i < n; i++) press1();
      step(2);
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (sb.size() != 0 && k < 200) begin
         step(1);
         k++;
      end
      if (sb.size() != 0) begin
         check("drain_timeout", 23'(sb.size()), 23'd0);
         sb.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t;
      int n;
      cyc       = 0;
      n_cmp     = 0;
      n_bad     = 0;
      i_rst     = 1'b1;
      bus.i_sw  = 1'b0;
      bus.i_clr = 1'b0;
      step(2);
      expect_at(cyc + 1, "reset", 0, 0, 0, 0, 0);
      step(1);
      i_rst = 1'b0;
      drain();

      // Single 3-cycle press.
      t = cyc;
      expect_at(t + 1, "a_sample", 0, 0, 0, 0, 0);
      expect_at(t + 2, "a_inc",    0, 1, 0, 0, 0);
      expect_at(t + 3, "a_seg",    0, 1, 0, 0, 1);
      expect_at(t + 6, "a_stay",   0, 1, 0, 0, 1);
      bus.i_sw = 1'b1;
      step(3);
      bus.i_sw = 1'b0;
      drain();

      // 20-cycle hold from 00: hold then auto-repeat.
      bus.i_clr = 1'b1;
      step(1);
      bus.i_clr = 1'b0;
      t = cyc;
      n = t + 1;
      expect_at(n + 1,  "b_inc1", 0, 1, 0, 0, 0);
      expect_at(n + 2,  "b_seg1", 0, 1, 0, 0, 1);
      expect_at(n + 8,  "b_pre2", 0, 1, 0, 0, 1);
      expect_at(n + 9,  "b_inc2", 0, 2, 0, 0, 1);
      expect_at(n + 12, "b_pre3", 0, 2, 0, 0, 2);
      expect_at(n + 13, "b_inc3", 0, 3, 0, 0, 2);
      expect_at(n + 17, "b_inc4", 0, 4, 0, 0, 3);
      expect_at(n + 18, "b_seg4", 0, 4, 0, 0, 4);
      expect_at(n + 24, "b_rel",  0, 4, 0, 0, 4);
      bus.i_sw = 1'b1;
      step(20);
      bus.i_sw = 1'b0;
      drain();

      // Back-to-back single-cycle presses to 98, then through the wrap.
      preload(98);
      t = cyc;
      expect_at(t + 1, "c_98",    9, 8, 0, 9, 8);
      expect_at(t + 2, "c_99",    9, 9, 0, 9, 8);
      expect_at(t + 3, "c_99seg", 9, 9, 0, 9, 9);
      expect_at(t + 4, "c_wrap",  0, 0, 1, 9, 9);
      expect_at(t + 5, "c_after", 0, 0, 0, 0, 0);
      expect_at(t + 8, "c_quiet", 0, 0, 0, 0, 0);
      bus.i_sw = 1'b1;
      step(1);
      bus.i_sw = 1'b0;
      step(1);
      bus.i_sw = 1'b1;
      step(1);
      bus.i_sw = 1'b0;
      drain();

      // Clear coincident with a press at 37; FSM still enters HOLD.
      preload(37);
      t = cyc;
      n = t + 1;
      expect_at(n,      "d_clr",   0, 0, 0, 3, 7);
      expect_at(n + 1,  "d_noinc", 0, 0, 0, 0, 0);
      expect_at(n + 8,  "d_hold",  0, 0, 0, 0, 0);
      expect_at(n + 9,  "d_hinc",  0, 1, 0, 0, 0);
      expect_at(n + 12, "d_rel",   0, 1, 0, 0, 1);
      bus.i_sw  = 1'b1;
      bus.i_clr = 1'b1;
      step(1);
      bus.i_clr = 1'b0;
      step(9);
      bus.i_sw = 1'b0;
      drain();

      // Switch held high across a reset pulse.
      t = cyc;
      expect_at(t + 1, "e_rst",  0, 0, 0, 0, 0);
      expect_at(t + 4, "e_held", 0, 0, 0, 0, 0);
      expect_at(t + 9, "e_end",  0, 0, 0, 0, 0);
      i_rst    = 1'b1;
      bus.i_sw = 1'b1;
      step(2);
      i_rst = 1'b0;
      step(5);
      bus.i_sw = 1'b0;
      drain();

      // Reset during auto-repeat at 12.
      preload(10);
      t = cyc;
      n = t + 1;
      expect_at(n + 1,  "f_11",     1, 1, 0, 1, 0);
      expect_at(n + 9,  "f_12",     1, 2, 0, 1, 1);
      expect_at(n + 11, "f_pre",    1, 2, 0, 1, 2);
      expect_at(n + 12, "f_rst",    0, 0, 0, 0, 0);
      expect_at(n + 13, "f_noinc",  0, 0, 0, 0, 0);
      expect_at(n + 20, "f_held",   0, 0, 0, 0, 0);
      expect_at(n + 23, "f_new",    0, 1, 0, 0, 0);
      expect_at(n + 24, "f_newseg", 0, 1, 0, 0, 1);
      bus.i_sw = 1'b1;
      step(12);
      i_rst = 1'b1;
      step(1);
      i_rst = 1'b0;
      step(7);
      bus.i_sw = 1'b0;
      step(2);
      bus.i_sw = 1'b1;
      step(1);
      bus.i_sw = 1'b0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
